// File: rtl/fixed_div_seq_if.sv
// Operand/result handshake bundle for the sequential Q16.16 divider.
// The divider takes the slave modport; its producer/consumer the master.
interface fixed_div_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_lhs;
    logic [31:0] in_rhs;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_div_by_zero;
    logic        out_overflow;
    logic        busy;

    modport master (
        output in_valid, in_lhs, in_rhs, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_div_by_zero, out_overflow, busy
    );

    modport slave (
        input  in_valid, in_lhs, in_rhs, out_ready,
        output in_ready, out_valid, out_result,
        output out_div_by_zero, out_overflow, busy
    );
endinterface

// File: rtl/fixed_div_seq.sv
// Sequential radix-2 restoring divider for Q16.16 fixed point,
// bit-identical to ({lhs,16'b0} / rhs) truncated toward zero.
module fixed_div_seq #(
    parameter int DECIMAL_WIDTH = 16,
    parameter int TOTAL_WIDTH   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    fixed_div_seq_if.slave  bus
);
    localparam int NUM_W = TOTAL_WIDTH + DECIMAL_WIDTH;
    localparam int CNT_W = $clog2(NUM_W);
    localparam int DEN_W = TOTAL_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [NUM_W-1:0]   quo_q, quo_d;
    logic [DEN_W-1:0]   den_q, den_d;
    logic [DEN_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               zero_q, zero_d;
    logic [TOTAL_WIDTH-1:0] res_q, res_d;
    logic               dz_q, dz_d;
    logic               ov_q, ov_d;

    logic [TOTAL_WIDTH-1:0] lhs_mag;
    logic [TOTAL_WIDTH-1:0] rhs_mag;
    logic [DEN_W:0]     trial;
    logic [DEN_W:0]     diff;
    logic               fits;
    logic [NUM_W-1:0]   qs;
    logic [NUM_W-1:TOTAL_WIDTH-1] qs_hi;

    assign lhs_mag = bus.in_lhs[TOTAL_WIDTH-1]
                   ? ('0 - bus.in_lhs) : bus.in_lhs;
    assign rhs_mag = bus.in_rhs[TOTAL_WIDTH-1]
                   ? ('0 - bus.in_rhs) : bus.in_rhs;

    // No borrow out of the trial subtraction means rem' >= den.
    assign trial = {rem_q, num_q[cnt_q]};
    assign diff  = trial - {1'b0, den_q};
    assign fits  = ~diff[DEN_W];

    assign qs    = neg_q ? ('0 - quo_q) : quo_q;
    assign qs_hi = qs[NUM_W-1:TOTAL_WIDTH-1];

    assign bus.in_ready        = (state_q == IDLE);
    assign bus.busy            = (state_q != IDLE);
    assign bus.out_valid       = (state_q == DONE);
    assign bus.out_result      = res_q;
    assign bus.out_div_by_zero = dz_q;
    assign bus.out_overflow    = ov_q;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        quo_d   = quo_q;
        den_d   = den_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        res_d   = res_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    num_d  = {lhs_mag, {DECIMAL_WIDTH{1'b0}}};
                    den_d  = {1'b0, rhs_mag};
                    rem_d  = '0;
                    quo_d  = '0;
                    cnt_d  = CNT_W'(NUM_W - 1);
                    zero_d = (bus.in_rhs == '0);
                    // On divide-by-zero neg carries the saturation sign.
                    if (bus.in_rhs == '0) begin
                        neg_d   = bus.in_lhs[TOTAL_WIDTH-1];
                        state_d = FIX;
                    end else begin
                        neg_d   = bus.in_lhs[TOTAL_WIDTH-1]
                                ^ bus.in_rhs[TOTAL_WIDTH-1];
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (fits) begin
                    rem_d        = diff[DEN_W-1:0];
                    quo_d[cnt_q] = 1'b1;
                end else begin
                    rem_d = trial[DEN_W-1:0];
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                if (zero_q) begin
                    res_d = neg_q ? {1'b1, {(TOTAL_WIDTH-1){1'b0}}}
                                  : {1'b0, {(TOTAL_WIDTH-1){1'b1}}};
                    dz_d  = 1'b1;
                    ov_d  = 1'b0;
                end else begin
                    res_d = qs[TOTAL_WIDTH-1:0];
                    dz_d  = 1'b0;
                    ov_d  = ~((&qs_hi) | ~(|qs_hi));
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            num_q   <= '0;
            quo_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            quo_q   <= quo_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end
endmodule
